matrix_mult_ctrl: RTL and testbench



---
 rtl/matrix_mult_ctrl_pkg.sv | 36 +++
 rtl/matrix_mult_ctrl_addr_counter.sv | 37 +++
 rtl/matrix_mult_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_matrix_mult_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_ctrl_pkg.sv
// Shared types and sizing for the systolic-array sequencing controller.
// Buffer depths fix the address widths carried in data_config_struct.
package matrix_mult_pkg;

  localparam int WIDTH             = 8;
  localparam int ROW_DEFAULT       = 4;
  localparam int COL_DEFAULT       = 4;
  localparam int W_SIZE            = 256;
  localparam int I_SIZE            = 256;
  localparam int O_SIZE            = 256;
  localparam int DRAIN_MAX_DEFAULT = ROW_DEFAULT + COL_DEFAULT + 4;

  localparam int WA_W  = $clog2(W_SIZE);
  localparam int IA_W  = $clog2(I_SIZE);
  localparam int OA_W  = $clog2(O_SIZE);
  // len spans 1..I_SIZE, so it needs one bit more than an input address
  localparam int LEN_W = $clog2(I_SIZE) + 1;

  typedef logic [WIDTH-1:0] elem_t;

  typedef struct packed {
    logic [WA_W-1:0]  w_base;
    logic [IA_W-1:0]  i_base;
    logic [OA_W-1:0]  o_base;
    logic [LEN_W-1:0] len;
  } data_config_struct;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } mm_state_e;

endpackage

// File: rtl/matrix_mult_ctrl_addr_counter.sv
// Loadable wrap-around address counter; wrap_o flags an increment that rolls over to zero.
module mm_addr_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] base_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = base_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i & ~load_i & (&cnt_q);

endmodule

// File: rtl/matrix_mult_ctrl.sv
// Sequences weight load, input/psum streaming and result write-back for the systolic array.
// Drives only SRAM enables/addresses; data buses bypass this block.
module matrix_mult_ctrl
  import matrix_mult_pkg::*;
#(
  parameter int ROW       = ROW_DEFAULT,
  parameter int DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              ext_en_i,
  input  data_config_struct data_config_i,
  output logic              wb_mem_cenb_o,
  output logic              wb_mem_wenb_o,
  output logic [WA_W-1:0]   wb_mem_addr_o,
  output logic              ib_mem_cenb_o,
  output logic              ib_mem_wenb_o,
  output logic [IA_W-1:0]   ib_mem_addr_o,
  output logic              ps_mem_cenb_o,
  output logic              ps_mem_wenb_o,
  output logic [OA_W-1:0]   ps_mem_addr_o,
  output logic              ob_mem_cenb_o,
  output logic              ob_mem_wenb_o,
  output logic [OA_W-1:0]   ob_mem_addr_o,
  output logic              sa_weight_en_o,
  output logic              sa_valid_o,
  input  logic              sa_result_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_MAX = (DRAIN_MAX > ROW) ? DRAIN_MAX : ROW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mm_state_e         state_q;
  data_config_struct cfg_q;
  logic              start_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  out_cnt_q;
  logic [LEN_W-1:0]  out_cnt_d;
  logic              wb_rd_q;
  logic              ip_rd_q;
  logic              sa_weight_en_q;
  logic              sa_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              ob_we;
  logic [WA_W-1:0]   wb_addr;
  logic [IA_W-1:0]   ip_off;
  logic [OA_W-1:0]   ob_addr;
  logic              unused_wb_wrap;
  logic              unused_ip_wrap;
  logic              unused_ob_wrap;

  assign accept = start_i & ~start_q & ~ext_en_i &
                  ((state_q == IDLE) || (state_q == DONE));

  assign ob_we     = sa_result_valid_i & ((state_q == STREAM) || (state_q == DRAIN));
  assign out_cnt_d = out_cnt_q + LEN_W'(ob_we);

  mm_addr_counter #(.W(WA_W)) u_wb_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load_i (accept),
    .base_i (data_config_i.w_base),
    .inc_i  (wb_rd_q),
    .cnt_o  (wb_addr),
    .wrap_o (unused_wb_wrap)
  );

  // Shared offset k: the input and psum buffers are read in lockstep from different bases
  mm_addr_counter #(.W(IA_W)) u_ip_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load_i (accept),
    .base_i ('0),
    .inc_i  (ip_rd_q),
    .cnt_o  (ip_off),
    .wrap_o (unused_ip_wrap)
  );

  mm_addr_counter #(.W(OA_W)) u_ob_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load_i (accept),
    .base_i (data_config_i.o_base),
    .inc_i  (ob_we),
    .cnt_o  (ob_addr),
    .wrap_o (unused_ob_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      cfg_q          <= '0;
      start_q        <= 1'b0;
      cnt_q          <= '0;
      out_cnt_q      <= '0;
      wb_rd_q        <= 1'b0;
      ip_rd_q        <= 1'b0;
      sa_weight_en_q <= 1'b0;
      sa_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      start_q        <= start_i;
      // SRAM read latency is one cycle, so array strobes trail the read enables
      sa_weight_en_q <= wb_rd_q;
      sa_valid_q     <= ip_rd_q;
      out_cnt_q      <= accept ? '0 : out_cnt_d;

      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            cfg_q <= data_config_i;
            cnt_q <= '0;
            if (data_config_i.len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= LOAD_W;
              busy_q  <= 1'b1;
              wb_rd_q <= 1'b1;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
            end
          end
        end
        LOAD_W: begin
          if (cnt_q == CNT_W'(ROW - 1)) begin
            state_q <= STREAM;
            cnt_q   <= '0;
            wb_rd_q <= 1'b0;
            ip_rd_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STREAM: begin
          if (LEN_W'(ip_off) == cfg_q.len - 1'b1) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
            ip_rd_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_cnt_d == cfg_q.len) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wb_rd_q <= 1'b0;
          ip_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_mem_cenb_o  = ~wb_rd_q;
  assign wb_mem_wenb_o  = 1'b1;
  assign wb_mem_addr_o  = wb_addr;

  assign ib_mem_cenb_o  = ~ip_rd_q;
  assign ib_mem_wenb_o  = 1'b1;
  assign ib_mem_addr_o  = cfg_q.i_base + ip_off;

  assign ps_mem_cenb_o  = ~ip_rd_q;
  assign ps_mem_wenb_o  = 1'b1;
  assign ps_mem_addr_o  = cfg_q.o_base + OA_W'(ip_off);

  assign ob_mem_cenb_o  = ~ob_we;
  assign ob_mem_wenb_o  = ~ob_we;
  assign ob_mem_addr_o  = ob_addr;

  assign sa_weight_en_o = sa_weight_en_q;
  assign sa_valid_o     = sa_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Cycle-by-cycle comparison of the controller against an arithmetic schedule of each run.
module tb_matrix_mult_ctrl;
  import matrix_mult_pkg::*;

  localparam int R    = 4;
  localparam int DMAX = 12;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              start_i = 1'b0;
  logic              ext_en_i = 1'b0;
  logic              sa_result_valid_i = 1'b0;
  data_config_struct data_config_i = '0;
  logic              wb_mem_cenb_o, wb_mem_wenb_o;
  logic [7:0]        wb_mem_addr_o;
  logic              ib_mem_cenb_o, ib_mem_wenb_o;
  logic [7:0]        ib_mem_addr_o;
  logic              ps_mem_cenb_o, ps_mem_wenb_o;
  logic [7:0]        ps_mem_addr_o;
  logic              ob_mem_cenb_o, ob_mem_wenb_o;
  logic [7:0]        ob_mem_addr_o;
  logic              sa_weight_en_o, sa_valid_o, busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prev_done = 1'b0;
  bit prev_err = 1'b0;

  matrix_mult_ctrl dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .start_i           (start_i),
    .ext_en_i          (ext_en_i),
    .data_config_i     (data_config_i),
    .wb_mem_cenb_o     (wb_mem_cenb_o),
    .wb_mem_wenb_o     (wb_mem_wenb_o),
    .wb_mem_addr_o     (wb_mem_addr_o),
    .ib_mem_cenb_o     (ib_mem_cenb_o),
    .ib_mem_wenb_o     (ib_mem_wenb_o),
    .ib_mem_addr_o     (ib_mem_addr_o),
    .ps_mem_cenb_o     (ps_mem_cenb_o),
    .ps_mem_wenb_o     (ps_mem_wenb_o),
    .ps_mem_addr_o     (ps_mem_addr_o),
    .ob_mem_cenb_o     (ob_mem_cenb_o),
    .ob_mem_wenb_o     (ob_mem_wenb_o),
    .ob_mem_addr_o     (ob_mem_addr_o),
    .sa_weight_en_o    (sa_weight_en_o),
    .sa_valid_o        (sa_valid_o),
    .sa_result_valid_i (sa_result_valid_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Address is only meaningful while enabled, except right after reset where it must be zero
  function automatic logic [31:0] mem_vec(input logic cenb, input logic wenb,
                                          input logic [7:0] addr, input bit mask);
    return {22'd0, cenb, wenb, (mask && cenb) ? 8'h00 : addr};
  endfunction

  task automatic run(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob,
                     input int len, input int nres, input int dly,
                     input bit hold, input bit ext, input int rst_c);
    int  dc, dent, last_w, n_cycles, wcnt, j;
    bit  run_ok, e_err, gone, act, rv, wb_en, ip_en, we, wen, val, e_busy, e_done, e_err_now;
    run_ok = !ext;
    dent   = R + len + 1;
    e_err  = 1'b0;
    dc     = 1 << 20;
    if (run_ok) begin
      if (len == 0) begin
        dc = 1; e_err = 1'b1;
      end else if (nres == len) begin
        last_w = R + 1 + len + dly;
        dc = (last_w + 1 > dent + 1) ? last_w + 1 : dent + 1;
      end else begin
        dc = dent + DMAX; e_err = 1'b1;
      end
    end
    n_cycles = run_ok ? dc + 3 : 8;
    if (rst_c >= 0) n_cycles = rst_c + 2;
    wcnt = 0;

    @(posedge clk_i); #1;
    start_i  = 1'b1;
    ext_en_i = ext;
    data_config_i.w_base = wb;
    data_config_i.i_base = ib;
    data_config_i.o_base = ob;
    data_config_i.len    = 9'(len);
    for (int c = 0; c < n_cycles; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
      end
      cyc = c;
      if (c == 1) begin
        if (!hold) start_i = 1'b0;
        data_config_i = data_config_struct'($urandom);
      end
      rstn_i = (c != rst_c);
      gone   = (rst_c >= 0) && (c > rst_c);
      j  = c - R - 2 - dly;
      rv = run_ok && (j >= 0) && (j < nres);
      sa_result_valid_i = rv;
      @(negedge clk_i);

      act   = run_ok && !gone;
      wb_en = act && len > 0 && c >= 1 && c <= R;
      ip_en = act && len > 0 && c >= R + 1 && c <= R + len;
      we    = act && len > 0 && rv && c >= R + 1 && c < dc;
      wen   = act && len > 0 && c >= 2 && c <= R + 1;
      val   = act && len > 0 && c >= R + 2 && c <= R + len + 1;
      e_busy = act && c >= 1 && c < dc;
      if (gone) begin
        e_done = 1'b0; e_err_now = 1'b0;
      end else if (!run_ok || c == 0) begin
        e_done = prev_done; e_err_now = prev_err;
      end else begin
        e_done = (c >= dc); e_err_now = (c >= dc) && e_err;
      end

      chk("wb", mem_vec(wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o, !gone),
          mem_vec(!wb_en, 1'b1, wb_en ? 8'(wb + c - 1) : 8'h00, !gone));
      chk("ib", mem_vec(ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o, !gone),
          mem_vec(!ip_en, 1'b1, ip_en ? 8'(ib + c - R - 1) : 8'h00, !gone));
      chk("ps", mem_vec(ps_mem_cenb_o, ps_mem_wenb_o, ps_mem_addr_o, !gone),
          mem_vec(!ip_en, 1'b1, ip_en ? 8'(ob + c - R - 1) : 8'h00, !gone));
      chk("ob", mem_vec(ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, !gone),
          mem_vec(!we, !we, we ? 8'(ob + wcnt) : 8'h00, !gone));
      chk("sa", {30'd0, sa_weight_en_o, sa_valid_o}, {30'd0, wen, val});
      chk("stat", {29'd0, busy_o, done_o, err_o}, {29'd0, e_busy, e_done, e_err_now});
      if (we) wcnt++;
    end
    if (rst_c >= 0) begin
      prev_done = 1'b0; prev_err = 1'b0;
    end else if (run_ok) begin
      prev_done = 1'b1; prev_err = e_err;
    end
    start_i  = 1'b0;
    ext_en_i = 1'b0;
    rstn_i   = 1'b1;
    sa_result_valid_i = 1'b0;
  endtask

  initial begin
    int len;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    cyc = -1;
    chk("rst_wb", mem_vec(wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o, 1'b0), 32'h300);
    chk("rst_ib", mem_vec(ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o, 1'b0), 32'h300);
    chk("rst_ps", mem_vec(ps_mem_cenb_o, ps_mem_wenb_o, ps_mem_addr_o, 1'b0), 32'h300);
    chk("rst_ob", mem_vec(ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, 1'b0), 32'h300);
    chk("rst_sa", {30'd0, sa_weight_en_o, sa_valid_o}, 32'd0);
    chk("rst_stat", {29'd0, busy_o, done_o, err_o}, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;

    run(8'h10, 8'h20, 8'h30, 3, 3, 2, 1'b0, 1'b0, -1);   // nominal
    run(8'h05, 8'hFE, 8'h40, 4, 4, 2, 1'b0, 1'b0, -1);   // input address wrap
    run(8'h11, 8'h22, 8'h33, 0, 0, 2, 1'b0, 1'b0, -1);   // zero length
    run(8'h10, 8'h20, 8'h30, 3, 2, 2, 1'b0, 1'b0, -1);   // drain timeout
    run(8'h10, 8'h20, 8'h30, 3, 3, 2, 1'b1, 1'b0, -1);   // start held through DONE
    run(8'h10, 8'h20, 8'h30, 3, 3, 2, 1'b0, 1'b1, -1);   // start blocked by ext_en
    run(8'h10, 8'h20, 8'h30, 5, 5, 2, 1'b0, 1'b0, 6);    // reset mid-STREAM
    run(8'h10, 8'h20, 8'h30, 3, 3, 2, 1'b0, 1'b0, -1);   // nominal after reset
    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(1, 20));
      run(8'($urandom), 8'($urandom), 8'($urandom), len, len,
          int'($urandom_range(1, 4)), 1'($urandom), 1'b0, -1);
    end
    run(8'hFD, 8'h00, 8'hFC, 6, 5, 1, 1'b0, 1'b0, -1);   // timeout with wrapping bases

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
